// File: rtl/load_seq_pkg.sv
// Shared types and constants for the load sequencer.
package load_seq_pkg;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      DWELL = 2'd2
   } seq_state_t;

   // Widest count supported; the all-ones compare value is sliced to WIDTH.
   localparam int unsigned MAX_WIDTH = 32;
   localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/load_sequencer_sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers, full/empty and occupancy.
// Flush wins over push/pop; push into a full FIFO or pop from an empty one is ignored.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == (PW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   // Next pointers, level and storage write
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer/level registers; contents are meaningless once pointers reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/load_sequencer.sv
// Feeds queued load values to a loadable counter, holding each one until the
// looped-back count has hit all-ones SWEEPS times before presenting the next.
module load_sequencer
   import load_seq_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter int SWEEPS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     val_valid_i,
   input  logic [WIDTH-1:0]         val_i,
   output logic                     val_ready_o,
   input  logic [WIDTH-1:0]         count_i,
   output logic                     load_o,
   output logic [WIDTH-1:0]         load_val_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int SW = $clog2(SWEEPS+1);
   localparam logic [WIDTH-1:0] CNT_MAX   = ALL_ONES[WIDTH-1:0];
   localparam logic [SW-1:0]    SWEEP_MAX = SW'(SWEEPS);

   seq_state_t       state_q, state_d;
   logic [SW-1:0]    sweep_q, sweep_d;
   logic             load_q, load_d;
   logic [WIDTH-1:0] load_val_q, load_val_d;

   logic             fifo_full, fifo_empty, push, pop;
   logic [WIDTH-1:0] fifo_head;

   // Ready is gated by reset so nothing is offered while the block is held clear
   assign val_ready_o = reset && !fifo_full;
   assign push        = val_valid_i && val_ready_o;
   assign load_o      = load_q;
   assign load_val_o  = load_val_q;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (val_i),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   // Next state, sweep counting and pop decision
   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      load_d     = load_q;
      load_val_d = load_val_q;
      pop        = 1'b0;
      if (flush_i) begin
         state_d = IDLE;
         sweep_d = '0;
         load_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               load_d = 1'b0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  load_val_d = fifo_head;
                  load_d     = 1'b1;
                  state_d    = ARM;
               end
            end
            ARM: begin
               // Counter is being loaded this cycle; its output is stale
               load_d  = 1'b1;
               sweep_d = '0;
               state_d = DWELL;
            end
            DWELL: begin
               load_d = 1'b1;
               if (sweep_q == SWEEP_MAX) begin
                  // Hold the value indefinitely if nothing is queued behind it
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     load_val_d = fifo_head;
                     state_d    = ARM;
                  end
               end else if (count_i == CNT_MAX) begin
                  sweep_d = sweep_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               load_d  = 1'b0;
            end
         endcase
      end
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         sweep_q    <= '0;
         load_q     <= 1'b0;
         load_val_q <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         load_q     <= load_d;
         load_val_q <= load_val_d;
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed and randomized checks of load_sequencer against a queue-based model.
module tb_load_sequencer;

   localparam int WIDTH  = 4;
   localparam int DEPTH  = 4;
   localparam int SWEEPS = 2;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset, flush_i, val_valid_i, val_ready_o, load_o;
   logic [WIDTH-1:0] val_i, count_i, load_val_o;
   logic [LW-1:0]    level_o;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: pending values, what is presented, and sweep progress
   logic [WIDTH-1:0] q[$];
   bit               m_busy, m_fresh, m_load;
   int               m_hits;
   logic [WIDTH-1:0] m_val;
   logic [WIDTH-1:0] cnt;

   always #5 clk = ~clk;

   load_sequencer #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .SWEEPS (SWEEPS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush_i),
      .val_valid_i (val_valid_i),
      .val_i       (val_i),
      .val_ready_o (val_ready_o),
      .count_i     (count_i),
      .load_o      (load_o),
      .load_val_o  (load_val_o),
      .level_o     (level_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_busy  = 1'b0;
      m_fresh = 1'b0;
      m_load  = 1'b0;
      m_hits  = 0;
      m_val   = '0;
      cnt     = '0;
   endtask

   // One clock: drive at negedge, predict, check after the rising edge.
   // Non-random count_i emulates a counter that loads the presented value and free-runs.
   task automatic cyc(input bit fl, input bit vv, input logic [WIDTH-1:0] vd, input bit rnd);
      bit acc, adv;
      @(negedge clk);
      flush_i     = fl;
      val_valid_i = vv;
      val_i       = vd;
      count_i     = rnd ? (($urandom_range(0, 2) == 0) ? '1 : WIDTH'($urandom)) : cnt;
      #1;
      chk("val_ready_o", 32'(val_ready_o), 32'(q.size() < DEPTH));
      acc = vv && !fl && (q.size() < DEPTH);
      if (fl) begin
         q.delete();
         m_busy  = 1'b0;
         m_fresh = 1'b0;
         m_hits  = 0;
         m_load  = 1'b0;
         cnt     = cnt + 1'b1;
      end else begin
         adv = (q.size() > 0) && (!m_busy || (!m_fresh && m_hits >= SWEEPS));
         if (m_busy && !m_fresh && count_i == '1 && m_hits < SWEEPS) m_hits++;
         m_fresh = 1'b0;
         if (adv) begin
            m_val   = q.pop_front();
            m_busy  = 1'b1;
            m_fresh = 1'b1;
            m_hits  = 0;
            m_load  = 1'b1;
            cnt     = m_val;
         end else begin
            cnt = cnt + 1'b1;
         end
         if (acc) q.push_back(vd);
      end
      @(posedge clk);
      #1;
      chk("load_o", 32'(load_o), 32'(m_load));
      chk("load_val_o", 32'(load_val_o), 32'(m_val));
      chk("level_o", 32'(level_o), 32'(q.size()));
   endtask

   initial begin
      logic [WIDTH-1:0] vals [7];
      int idx, guard;
      vals = '{4'd9, 4'd13, 4'd3, 4'd5, 4'd7, 4'd11, 4'd2};

      // Reset state
      reset       = 1'b0;
      flush_i     = 1'b0;
      val_valid_i = 1'b1;
      val_i       = 4'd1;
      count_i     = '0;
      model_reset();
      #12;
      chk("rst ready", 32'(val_ready_o), 32'd0);
      chk("rst load", 32'(load_o), 32'd0);
      chk("rst load_val", 32'(load_val_o), 32'd0);
      chk("rst level", 32'(level_o), 32'd0);
      val_valid_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Idle for 20 cycles
      repeat (20) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("idle load", 32'(load_o), 32'd0);

      // Single push of 9: two-edge latency to ARM
      cyc(1'b0, 1'b1, 4'd9, 1'b0);
      chk("push level", 32'(level_o), 32'd1);
      chk("push load", 32'(load_o), 32'd0);
      cyc(1'b0, 1'b0, '0, 1'b0);
      chk("arm load", 32'(load_o), 32'd1);
      chk("arm val", 32'(load_val_o), 32'd9);
      repeat (60) cyc(1'b0, 1'b0, '0, 1'b0);
      chk("hold load", 32'(load_o), 32'd1);
      chk("hold val", 32'(load_val_o), 32'd9);

      // Back-to-back pushes with proper valid/ready holding
      idx   = 0;
      guard = 0;
      while (idx < 7 && guard < 300) begin
         bit will;
         will = (q.size() < DEPTH);
         cyc(1'b0, 1'b1, vals[idx], 1'b0);
         if (will) idx++;
         guard++;
      end
      chk("b2b all accepted", 32'(idx), 32'd7);
      repeat (260) cyc(1'b0, 1'b0, '0, 1'b0);
      chk("b2b last value", 32'(load_val_o), 32'd2);
      chk("b2b drained", 32'(level_o), 32'd0);

      // Flush mid-DWELL with three queued; push on the flush edge is dropped
      cyc(1'b0, 1'b1, 4'd9, 1'b0);
      cyc(1'b0, 1'b1, 4'd13, 1'b0);
      cyc(1'b0, 1'b1, 4'd3, 1'b0);
      cyc(1'b0, 1'b1, 4'd5, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
      chk("pre-flush level", 32'(level_o), 32'd3);
      cyc(1'b1, 1'b1, 4'd7, 1'b0);
      chk("flush level", 32'(level_o), 32'd0);
      chk("flush load", 32'(load_o), 32'd0);
      chk("flush val", 32'(load_val_o), 32'd9);
      repeat (5) cyc(1'b0, 1'b0, '0, 1'b0);

      // Randomized traffic with random counts and occasional flushes
      repeat (400) cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1),
                       WIDTH'($urandom), 1'b1);

      // Asynchronous reset mid-DWELL, between clock edges
      repeat (3) cyc(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
      repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
      chk("pre-reset load", 32'(load_o), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async load", 32'(load_o), 32'd0);
      chk("async load_val", 32'(load_val_o), 32'd0);
      chk("async level", 32'(level_o), 32'd0);
      chk("async ready", 32'(val_ready_o), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (5) cyc(1'b0, 1'b0, '0, 1'b0);
      chk("post-reset load", 32'(load_o), 32'd0);
      repeat (40) cyc(1'b0, ($urandom_range(0, 1) == 1), WIDTH'($urandom), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
